// File: rtl/ccr_stack_controller.sv
// Condition code register plus the shadow stack that saves it across nested interrupts.
// Sits beside the ALU in execute: commits flags, pushes on interrupt entry, pops on RTI.
module ccr_stack_controller #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flagWrEn,
    input  logic [3:0]       flagsIn,
    input  logic             intEnter,
    input  logic             rtiRestore,
    output logic [3:0]       ccr,
    output logic [3:0]       freezedCCR,
    output logic [CNT_W-1:0] depth,
    output logic             stackFull,
    output logic             stackEmpty,
    output logic             errOverflow,
    output logic             errUnderflow
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // Sized to the full pointer range so depth indexes it without truncation;
    // entries at or above DEPTH are never written.
    logic [3:0]       stack [0:(1 << CNT_W) - 1];
    logic [3:0]       nextFlags;
    logic [3:0]       topFlags;
    logic [CNT_W-1:0] topIdx;
    logic             pushEn;

    assign stackFull  = (depth == DEPTH_C);
    assign stackEmpty = (depth == '0);
    assign topIdx     = depth - ONE_C;
    assign topFlags   = stack[topIdx];
    assign freezedCCR = stackEmpty ? 4'b0000 : topFlags;
    assign nextFlags  = flagWrEn ? flagsIn : ccr;

    // Tail-chain (intEnter with rtiRestore) never writes the stack.
    assign pushEn = reset && !stall && intEnter && !rtiRestore && !stackFull;

    // NOTE: the stack array has no reset; depth alone marks which entries are valid,
    // so clearing the storage would only add reset fan-out for no behavioural gain.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            stack[depth] <= nextFlags;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values of ccr/depth, matching the "visible after edge N" timing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ccr          <= 4'b0000;
            depth        <= '0;
            errOverflow  <= 1'b0;
            errUnderflow <= 1'b0;
        end else if (!stall) begin
            if (intEnter && rtiRestore) begin
                if (stackEmpty) begin
                    errUnderflow <= 1'b1;
                end else begin
                    ccr <= topFlags;
                end
            end else if (rtiRestore) begin
                if (stackEmpty) begin
                    errUnderflow <= 1'b1;
                end else begin
                    ccr   <= topFlags;
                    depth <= depth - ONE_C;
                end
            end else if (intEnter) begin
                ccr <= nextFlags;
                if (stackFull) begin
                    errOverflow <= 1'b1;
                end else begin
                    depth <= depth + ONE_C;
                end
            end else begin
                ccr <= nextFlags;
            end
        end
    end

endmodule

// File: doc/ccr_stack_controller.md
# ccr_stack_controller

Owns the processor's condition code register (CCR) and the shadow stack that saves it across interrupts. Sits beside the ALU in the execute stage. Each cycle it:
- commits the ALU's flag outputs into the CCR;
- pushes the CCR on interrupt entry;
- pops it on RTI.

It drives the ALU's live flag inputs and its `freezedCCR` input, so nested interrupts restore correctly.

## Interface
Parameters:
- `DEPTH`, default 4: shadow stack entries (nesting levels supported); legal range 1 to 15.
- `CNT_W`, default 3: width of `depth`; must satisfy 2^CNT_W > DEPTH.

Ports (flag vectors are packed [3: NF, 2: OF, 1: CF, 0: ZF]):
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on rising edge of `clk`.
- `stall` in 1: pipeline stall; when 1, no state changes.
- `flagWrEn` in 1: commit `flagsIn` to the CCR this cycle.
- `flagsIn` in 4: ALU flag outputs {negativeFlagOut, overFlowFlagOut, carryFlagOut, zeroFlagOut}.
- `intEnter` in 1: interrupt entry; push the CCR.
- `rtiRestore` in 1: return from interrupt; pop the CCR.
- `ccr` out 4: current CCR, registered; drives the ALU flag inputs.
- `freezedCCR` out 4: top stack entry; 4'b0000 when the stack is empty.
- `depth` out CNT_W: number of valid stack entries, registered.
- `stackFull` out 1: depth == DEPTH.
- `stackEmpty` out 1: depth == 0.
- `errOverflow` out 1: sticky; a push was attempted while full.
- `errUnderflow` out 1: sticky; a pop was attempted while empty.

## Operation
Definitions:
- `nextFlags` = `flagsIn` if `flagWrEn`, else `ccr`.
- `top` = `stack[depth-1]`.

State machine: none beyond the stack pointer. State is the CCR register, stack array and `depth` counter, plus two sticky error bits.

When `stall`=1, all registers hold; inputs are ignored. Otherwise the first matching case applies:
- **`intEnter`=1, `rtiRestore`=1 (tail-chain):**
  - `ccr` <= `top` (or `ccr` unchanged if empty).
  - Stack and `depth` unchanged; this is pop-then-push of the same value.
  - Empty stack also sets `errUnderflow`.
  - `flagWrEn` ignored.
- **`rtiRestore`=1, stack not empty:** `ccr` <= `top`; `depth` <= `depth`-1. `flagWrEn` ignored.
- **`rtiRestore`=1, stack empty:** `ccr` unchanged; `errUnderflow` <= 1; `depth` stays 0.
- **`intEnter`=1, stack not full:** `stack[depth]` <= `nextFlags`; `ccr` <= `nextFlags`; `depth` <= `depth`+1.
  - Pushing `nextFlags` preserves the flags of the instruction completing in the same cycle.
- **`intEnter`=1, stack full:**
  - `ccr` <= `nextFlags`; stack and `depth` unchanged.
  - `errOverflow` <= 1; the oldest entries are never overwritten.
- **Otherwise:** `ccr` <= `nextFlags`.

Combinational outputs and data rules:
- `freezedCCR`, `stackFull`, `stackEmpty` are combinational from registered state only. No input-to-output combinational path.
- Stack entries above `depth` are don't-care; they are not cleared on pop.
- `depth` never wraps: it saturates at 0 and at DEPTH per the rules above.

## Timing
- Reset (`reset`=0 at an edge):
  - `ccr`=0, `depth`=0, `errOverflow`=0, `errUnderflow`=0.
  - Hence `freezedCCR`=0, `stackEmpty`=1, `stackFull`=0.
  - Reset overrides `stall`, `intEnter` and `rtiRestore`.
  - Reset mid-nesting discards all saved entries.
- Latency: an input sampled at edge N is visible on `ccr`, `depth` and status outputs after edge N.
  - `freezedCCR` reflects a push or pop in the same cycle `depth` changes.
- Back-to-back operations are supported every cycle: push/push, pop/pop, push/pop.
- Sticky error bits clear only on reset.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `intEnter`=1 and `flagWrEn`=1, `flagsIn`=4'b1111. Required: `ccr`=0, `depth`=0, `stackEmpty`=1, `freezedCCR`=0. Release reset, then `flagWrEn`=1 with `flagsIn`=4'b0101. Required: `ccr`=4'b0101 one edge later.
- **Nested push/pop:** starting from `ccr`=4'b0011, `intEnter`. Then `flagsIn`=4'b1000 with `flagWrEn`+`intEnter`. Then `rtiRestore` twice. Required:
  - `depth` goes 1, 2, 1, 0.
  - `freezedCCR` goes 0011, 1000, 0011, 0000.
  - `ccr` after the pops is 1000, then 0011.
- **Overflow:** with DEPTH=4, perform 5 pushes of distinct values 1, 2, 3, 4, 5. Required:
  - `depth`=4, `stackFull`=1, `errOverflow`=1.
  - Subsequent 4 pops restore 4, 3, 2, 1.
- **Underflow:** `rtiRestore` with an empty stack and `ccr`=4'b0110. Required: `ccr` stays 0110, `errUnderflow`=1, `depth`=0. The error persists after further valid pushes.
- **Stall:** hold `stall`=1 while asserting `intEnter`, `rtiRestore` and `flagWrEn`. Required: no change to any output. Deassert `stall`; the next operation behaves normally.
- **Tail-chain:** with `depth`=2 and top=4'b1010, assert `intEnter`+`rtiRestore` with `flagWrEn`=1, `flagsIn`=4'b0001. Required: `ccr`=4'b1010, `depth`=2, `freezedCCR`=4'b1010, no error bits set.
